// File: rtl/tl_a_arb_pkg.sv
// tl_a_arb_pkg: shared opcodes, arbiter state type and beat-count helpers for the A-channel arbiter.
package tl_a_arb_pkg;
   localparam logic [2:0] PUT_FULL    = 3'd0;
   localparam logic [2:0] PUT_PARTIAL = 3'd1;
   localparam logic [2:0] ARITHMETIC  = 3'd2;
   localparam logic [2:0] LOGICAL     = 3'd3;
   localparam logic [2:0] GET         = 3'd4;
   localparam logic [2:0] HINT        = 3'd5;

   typedef enum logic [1:0] {IDLE, HOLD, BURST} arb_state_t;

   // Only data-carrying opcodes larger than one beat span several beats.
   function automatic logic is_multibeat(input logic [2:0] opcode, input int size, input int lg_bytes);
      return (opcode <= LOGICAL) && (size > lg_bytes);
   endfunction

   function automatic int beats_m1(input int size, input int lg_bytes);
      return (1 << (size - lg_bytes)) - 1;
   endfunction
endpackage

// File: rtl/tl_a_channel_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first valid requester at or after ptr (wrapping).
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IW    = 2
) (
   input  logic [N_REQ-1:0] valid,
   input  logic [IW-1:0]    ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IW-1:0]    idx,
   output logic             any
);
   // Scan from farthest to nearest so the nearest valid requester wins.
   always_comb begin
      idx = '0;
      any = |valid;
      for (int k = N_REQ - 1; k >= 0; k--)
         if (valid[(int'(ptr) + k) % N_REQ]) idx = IW'((int'(ptr) + k) % N_REQ);
      grant = any ? N_REQ'(1) << idx : '0;
   end
endmodule

// File: rtl/tl_a_channel_arbiter.sv
// tl_a_channel_arbiter: round-robin, burst-locked, stall-holding TileLink A-channel arbiter.
// Define TL_A_ARB_CHECK_EN to enable simulation-only protocol checks.
module tl_a_channel_arbiter
   import tl_a_arb_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int DATA_BYTES = 8,
   parameter int ADDR_W     = 14,
   parameter int SOURCE_W   = 8,
   parameter int SIZE_W     = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [N_REQ-1:0]             in_valid,
   output logic [N_REQ-1:0]             in_ready,
   input  logic [N_REQ*3-1:0]           in_opcode,
   input  logic [N_REQ*3-1:0]           in_param,
   input  logic [N_REQ*SIZE_W-1:0]      in_size,
   input  logic [N_REQ*SOURCE_W-1:0]    in_source,
   input  logic [N_REQ*ADDR_W-1:0]      in_address,
   input  logic [N_REQ*DATA_BYTES-1:0]  in_mask,
   input  logic [N_REQ*8*DATA_BYTES-1:0] in_data,
   input  logic [N_REQ-1:0]             in_corrupt,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [2:0]                   out_opcode,
   output logic [2:0]                   out_param,
   output logic [SIZE_W-1:0]            out_size,
   output logic [SOURCE_W-1:0]          out_source,
   output logic [ADDR_W-1:0]            out_address,
   output logic [DATA_BYTES-1:0]        out_mask,
   output logic [8*DATA_BYTES-1:0]      out_data,
   output logic                         out_corrupt,
   output logic [N_REQ-1:0]             out_grant
);
   localparam int LG    = $clog2(DATA_BYTES);
   localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = 2**SIZE_W - 1 - LG;
   localparam int DW    = 8 * DATA_BYTES;

   arb_state_t       state, state_nx;
   logic [IW-1:0]    rr_ptr, rr_ptr_nx, lock_idx, lock_idx_nx, pick_idx, sel_idx;
   logic [CNT_W-1:0] beat_cnt, beat_cnt_nx;
   logic [N_REQ-1:0] pick_oh;
   logic             pick_any, fire, multi;

   rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
      .valid (in_valid),
      .ptr   (rr_ptr),
      .grant (pick_oh),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         lock_idx <= '0;
         beat_cnt <= '0;
      end else begin
         state    <= state_nx;
         rr_ptr   <= rr_ptr_nx;
         lock_idx <= lock_idx_nx;
         beat_cnt <= beat_cnt_nx;
      end
   end

   // HOLD shares IDLE's first-beat handling; only the grant source differs.
   always_comb begin
      state_nx    = state;
      rr_ptr_nx   = rr_ptr;
      lock_idx_nx = lock_idx;
      beat_cnt_nx = beat_cnt;
      if (state == BURST) begin
         if (fire) begin
            beat_cnt_nx = beat_cnt - 1'b1;
            state_nx    = (beat_cnt == CNT_W'(1)) ? IDLE : BURST;
         end
      end else if (fire) begin
         rr_ptr_nx   = (sel_idx == IW'(N_REQ - 1)) ? '0 : sel_idx + 1'b1;
         lock_idx_nx = sel_idx;
         state_nx    = multi ? BURST : IDLE;
         beat_cnt_nx = multi ? CNT_W'(beats_m1(int'(out_size), LG)) : '0;
      end else if (out_valid) begin
         state_nx    = HOLD;
         lock_idx_nx = sel_idx;
      end
   end

   always_comb begin
      sel_idx     = (state == IDLE) ? pick_idx : lock_idx;
      out_valid   = !reset && ((state == IDLE) ? pick_any : in_valid[lock_idx]);
      out_grant   = !out_valid ? '0 : (state == IDLE) ? pick_oh : N_REQ'(1) << lock_idx;
      fire        = out_valid && out_ready;
      in_ready    = out_ready ? out_grant : '0;
      out_opcode  = '0;
      out_param   = '0;
      out_size    = '0;
      out_source  = '0;
      out_address = '0;
      out_mask    = '0;
      out_data    = '0;
      out_corrupt = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (out_grant[i]) begin
            out_opcode  |= in_opcode[3*i +: 3];
            out_param   |= in_param[3*i +: 3];
            out_size    |= in_size[SIZE_W*i +: SIZE_W];
            out_source  |= in_source[SOURCE_W*i +: SOURCE_W];
            out_address |= in_address[ADDR_W*i +: ADDR_W];
            out_mask    |= in_mask[DATA_BYTES*i +: DATA_BYTES];
            out_data    |= in_data[DW*i +: DW];
            out_corrupt |= in_corrupt[i];
         end
      end
      multi = is_multibeat(out_opcode, int'(out_size), LG);
   end

`ifdef TL_A_ARB_CHECK_EN
`ifndef SYNTHESIS
   localparam int PW = 6 + SIZE_W + SOURCE_W + ADDR_W + DATA_BYTES + DW + 1;
   logic          stall_q;
   logic [IW-1:0] idx_q;
   logic [PW-1:0] pay, pay_q;
   assign pay = {out_opcode, out_param, out_size, out_source, out_address, out_mask, out_data, out_corrupt};
   always_ff @(posedge clock) begin
      stall_q <= !reset && out_valid && !out_ready;
      idx_q   <= sel_idx;
      pay_q   <= pay;
      if (!reset) begin
         assert ($onehot0(out_grant)) else $error("grant not one-hot0 %b, requester %0d", out_grant, sel_idx);
         if (stall_q) begin
            assert (in_valid[idx_q]) else $error("valid dropped before fire, requester %0d", idx_q);
            assert (pay == pay_q) else $error("payload changed while stalled, requester %0d", idx_q);
         end
         if (out_valid && out_opcode == PUT_FULL && !multi && state != BURST)
            assert (|out_mask) else $error("zero mask on single-beat PutFull, requester %0d", sel_idx);
      end
   end
`endif
`else
   // checks disabled
`endif
endmodule
